// File: rtl/ball_motion_scheduler_if.sv
// Handshake/bus bundle between the VGA timing side and the ball motion scheduler.
// The slave modport is the scheduler; the master is the timing generator / renderer side.
interface ball_motion_scheduler_if #(
   parameter int NBALLS = 4
);
   logic                  frame_start;
   logic                  vblank;
   logic [7:0]            top;
   logic [2*NBALLS-1:0]   start_dir;
   logic [7*NBALLS-1:0]   pos_h;
   logic [7*NBALLS-1:0]   pos_v;
   logic                  updated;
   logic                  busy;
   logic                  overrun;

   modport master (
      output frame_start, vblank, top, start_dir,
      input  pos_h, pos_v, updated, busy, overrun
   );

   modport slave (
      input  frame_start, vblank, top, start_dir,
      output pos_h, pos_v, updated, busy, overrun
   );
endinterface

// File: rtl/ball_motion_scheduler.sv
// Time-multiplexed bounce/step engine for NBALLS balls; results are published only in vblank.
// Optional SCHED_PAUSE_EN adds i_pause, which freezes the frame counter and suppresses triggers.
module ball_motion_scheduler #(
   parameter int NBALLS     = 4,
   parameter int LO_BOUND   = 10,
   parameter int H_HI_BOUND = 70,
   parameter int V_HI_BOUND = 50
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
`ifdef SCHED_PAUSE_EN
   input  logic                      i_pause,
`endif
   ball_motion_scheduler_if.slave    bus
);

   localparam int KW = (NBALLS > 1) ? $clog2(NBALLS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_WAIT_VBL,
      S_COMMIT
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [KW-1:0]         r_k;
   logic [KW-1:0]         w_k_next;
   logic [7:0]            r_cnt;
   logic [6:0]            r_sh_h [NBALLS];
   logic [6:0]            r_sh_v [NBALLS];
   logic [NBALLS-1:0]     r_dir_h;
   logic [NBALLS-1:0]     r_dir_v;
   logic [7*NBALLS-1:0]   r_pos_h;
   logic [7*NBALLS-1:0]   r_pos_v;
   logic                  r_updated;
   logic                  r_busy;
   logic                  r_overrun;

   logic                  w_cnt_en;
   logic                  w_trig;
   logic [6:0]            w_cur_h;
   logic [6:0]            w_cur_v;
   logic                  w_ndir_h;
   logic                  w_ndir_v;
   logic [6:0]            w_new_h;
   logic [6:0]            w_new_v;

`ifdef SCHED_PAUSE_EN
   assign w_cnt_en = bus.frame_start & ~i_pause;
`else
   assign w_cnt_en = bus.frame_start;
`endif
   assign w_trig = w_cnt_en && (r_cnt == bus.top);

   // Frame divider runs in every state; triggers outside IDLE are dropped by the FSM.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= 8'd0;
      end else if (w_cnt_en) begin
         r_cnt <= (r_cnt == bus.top) ? 8'd0 : r_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         r_k     <= w_k_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_k_next = r_k;
      case (r_state)
         S_IDLE: begin
            if (w_trig) begin
               w_next   = S_SWEEP;
               w_k_next = '0;
            end
         end
         S_SWEEP: begin
            w_k_next = r_k + 1'b1;
            if (r_k == KW'(NBALLS - 1))
               w_next = S_WAIT_VBL;
         end
         S_WAIT_VBL: begin
            if (bus.vblank)
               w_next = S_COMMIT;
         end
         S_COMMIT: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Shared step datapath, operating on ball r_k only.
   always_comb begin
      w_cur_h = r_sh_h[r_k];
      w_cur_v = r_sh_v[r_k];

      if (w_cur_h < 7'(LO_BOUND))
         w_ndir_h = 1'b1;
      else if (w_cur_h > 7'(H_HI_BOUND))
         w_ndir_h = 1'b0;
      else
         w_ndir_h = r_dir_h[r_k];

      if (w_cur_v < 7'(LO_BOUND))
         w_ndir_v = 1'b1;
      else if (w_cur_v > 7'(V_HI_BOUND))
         w_ndir_v = 1'b0;
      else
         w_ndir_v = r_dir_v[r_k];

      w_new_h = w_ndir_h ? (w_cur_h + 7'd1) : (w_cur_h - 7'd1);
      w_new_v = w_ndir_v ? (w_cur_v + 7'd1) : (w_cur_v - 7'd1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NBALLS; i++) begin
            r_sh_h[i]           <= 7'(16 + 8 * i);
            r_sh_v[i]           <= 7'd32;
            r_pos_h[7*i +: 7]   <= 7'(16 + 8 * i);
            r_pos_v[7*i +: 7]   <= 7'd32;
            r_dir_h[i]          <= bus.start_dir[2*i];
            r_dir_v[i]          <= bus.start_dir[2*i+1];
         end
      end else begin
         if (r_state == S_SWEEP) begin
            r_sh_h[r_k]  <= w_new_h;
            r_sh_v[r_k]  <= w_new_v;
            r_dir_h[r_k] <= w_ndir_h;
            r_dir_v[r_k] <= w_ndir_v;
         end
         // Committed coordinates only move here, so renderers never see a half-updated set.
         if (r_state == S_COMMIT) begin
            for (int i = 0; i < NBALLS; i++) begin
               r_pos_h[7*i +: 7] <= r_sh_h[i];
               r_pos_v[7*i +: 7] <= r_sh_v[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy    <= 1'b0;
         r_updated <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_busy    <= (w_next != S_IDLE);
         r_updated <= (w_next == S_COMMIT);
         r_overrun <= r_overrun | (w_trig && (r_state != S_IDLE));
      end
   end

   assign bus.pos_h   = r_pos_h;
   assign bus.pos_v   = r_pos_v;
   assign bus.updated = r_updated;
   assign bus.busy    = r_busy;
   assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_ball_motion_scheduler.sv
// Randomized bench for ball_motion_scheduler against a per-ball bounce model.
// Pause scenarios are compiled only when SCHED_PAUSE_EN is defined.
module tb_ball_motion_scheduler;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset;
`ifdef SCHED_PAUSE_EN
   logic pause;
`endif
   always #5 clk = ~clk;

   ball_motion_scheduler_if #(.NBALLS(NB)) bus ();

   ball_motion_scheduler #(.NBALLS(NB)) dut (
      .i_clk   (clk),
      .i_reset (reset),
`ifdef SCHED_PAUSE_EN
      .i_pause (pause),
`endif
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int upd_cnt = 0;

   always @(posedge clk) if (bus.updated === 1'b1) upd_cnt <= upd_cnt + 1;

   // model: ball positions, directions, frame divider
   int mh[NB], mv[NB], mdh[NB], mdv[NB];
   int mcnt, mtop;

   function automatic void m_reset(input logic [7:0] sd, input int tp);
      for (int i = 0; i < NB; i++) begin
         mh[i] = 16 + 8 * i; mv[i] = 32;
         mdh[i] = sd[2*i]; mdv[i] = sd[2*i+1];
      end
      mcnt = 0; mtop = tp;
   endfunction

   function automatic void m_step();
      for (int i = 0; i < NB; i++) begin
         if (mh[i] < 10) mdh[i] = 1; else if (mh[i] > 70) mdh[i] = 0;
         if (mv[i] < 10) mdv[i] = 1; else if (mv[i] > 50) mdv[i] = 0;
         mh[i] = (mdh[i] != 0) ? (mh[i] + 1) % 128 : (mh[i] + 127) % 128;
         mv[i] = (mdv[i] != 0) ? (mv[i] + 1) % 128 : (mv[i] + 127) % 128;
      end
   endfunction

   function automatic bit m_frame();
      if (mcnt == mtop) begin mcnt = 0; return 1'b1; end
      mcnt++;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input logic [7:0] sd, input int tp);
      reset = 1'b1; bus.start_dir = sd; bus.top = 8'(tp);
      bus.frame_start = 1'b0; bus.vblank = 1'b1;
      tick(); tick();
      reset = 1'b0;
      m_reset(sd, tp);
   endtask

   task automatic check_pos(input string nm);
      for (int i = 0; i < NB; i++) begin
         n_vec++;
         if (bus.pos_h[7*i +: 7] !== 7'(mh[i])) begin
            n_err++;
            $display("FAIL %s ball%0d h: got %0d exp %0d", nm, i, bus.pos_h[7*i +: 7], mh[i]);
         end
         n_vec++;
         if (bus.pos_v[7*i +: 7] !== 7'(mv[i])) begin
            n_err++;
            $display("FAIL %s ball%0d v: got %0d exp %0d", nm, i, bus.pos_v[7*i +: 7], mv[i]);
         end
      end
   endtask

   // One frame pulse; on a trigger, waits (bounded) for commit with random vblank and checks.
   task automatic frame_and_commit(input string nm, input bit rand_vbl, output bit trig);
      bit seen;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      trig = m_frame();
      if (trig) begin
         m_step();
         seen = 1'b0;
         for (int n = 0; n < 60 && !seen; n++) begin
            if (bus.updated === 1'b1) seen = 1'b1;
            else begin
               if (rand_vbl) bus.vblank = 1'($urandom_range(0, 1));
               tick();
            end
         end
         bus.vblank = 1'b1;
         n_vec++;
         if (!seen) begin
            n_err++;
            $display("FAIL %s commit timeout: got no updated exp updated", nm);
         end
         tick();
         check_pos(nm);
      end else begin
         n_vec++;
         if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy on non-trigger frame: got %b exp 0", nm, bus.busy);
         end
      end
   endtask

   task automatic test_reset();
      do_reset(8'b01_10_11_00, 0);
      check_pos("reset_pos");
      n_vec++;
      if ({bus.updated, bus.busy, bus.overrun} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got %b exp 000", {bus.updated, bus.busy, bus.overrun});
      end
   endtask

   task automatic test_first_step();
      int eh[NB] = '{15, 25, 31, 41};
      int ev[NB] = '{31, 33, 33, 31};
      bus.frame_start = 1'b1;
      void'(m_frame());
      m_step();
      for (int j = 1; j <= NB + 3; j++) begin
         tick();
         if (j == 1) bus.frame_start = 1'b0;
         n_vec++;
         if (bus.busy !== (j <= NB + 2)) begin
            n_err++;
            $display("FAIL first_busy cyc t+%0d: got %b exp %b", j, bus.busy, (j <= NB + 2));
         end
         n_vec++;
         if (bus.updated !== (j == NB + 2)) begin
            n_err++;
            $display("FAIL first_updated cyc t+%0d: got %b exp %b", j, bus.updated, (j == NB + 2));
         end
      end
      check_pos("first_model");
      for (int i = 0; i < NB; i++) begin
         n_vec++;
         if (bus.pos_h[7*i +: 7] !== 7'(eh[i]) || bus.pos_v[7*i +: 7] !== 7'(ev[i])) begin
            n_err++;
            $display("FAIL first_literal ball%0d: got (%0d,%0d) exp (%0d,%0d)", i,
                     bus.pos_h[7*i +: 7], bus.pos_v[7*i +: 7], eh[i], ev[i]);
         end
      end
   endtask

   task automatic test_top2();
      int u0;
      bit trig;
      do_reset(8'($urandom), 2);
      u0 = upd_cnt;
      for (int f = 0; f < 9; f++) begin
         frame_and_commit("top2", 1'b0, trig);
         n_vec++;
         if (trig !== ((f % 3) == 2)) begin
            n_err++;
            $display("FAIL top2_model frame %0d: got trig %b exp %b", f, trig, ((f % 3) == 2));
         end
         repeat (6) tick();
      end
      n_vec++;
      if (upd_cnt - u0 != 3) begin
         n_err++;
         $display("FAIL top2_commits: got %0d exp 3", upd_cnt - u0);
      end
   endtask

   task automatic test_bounce();
      bit trig, bh, bv;
      do_reset(8'b01_10_11_00, 0);
      for (int f = 0; f < 90; f++) begin
         bh = (mh[3] == 71) && (mdh[3] == 1);
         bv = (mv[0] == 9) && (mdv[0] == 0);
         frame_and_commit("bounce", 1'b0, trig);
         if (bh) begin
            n_vec++;
            if (bus.pos_h[3*7 +: 7] !== 7'd70) begin
               n_err++;
               $display("FAIL bounce_h_hi: got %0d exp 70", bus.pos_h[3*7 +: 7]);
            end
         end
         if (bv) begin
            n_vec++;
            if (bus.pos_v[0 +: 7] !== 7'd10) begin
               n_err++;
               $display("FAIL bounce_v_lo: got %0d exp 10", bus.pos_v[0 +: 7]);
            end
         end
         repeat (2) tick();
      end
   endtask

   task automatic test_random_walk();
      bit trig;
      for (int r = 0; r < 3; r++) begin
         do_reset(8'($urandom), $urandom_range(0, 3));
         for (int f = 0; f < 60; f++) begin
            frame_and_commit("random", 1'b1, trig);
            repeat ($urandom_range(1, 10)) tick();
         end
      end
   endtask

   task automatic test_vblank_hold();
      logic [7*NB-1:0] ph, pv;
      do_reset(8'($urandom), 0);
      ph = bus.pos_h; pv = bus.pos_v;
      check_pos("hold_init");
      bus.vblank = 1'b0;
      bus.frame_start = 1'b1;
      void'(m_frame());
      m_step();
      tick();
      bus.frame_start = 1'b0;
      for (int c = 0; c < NB + 500; c++) begin
         n_vec++;
         if (bus.busy !== 1'b1 || bus.pos_h !== ph || bus.pos_v !== pv) begin
            n_err++;
            $display("FAIL hold cyc %0d: got busy %b pos %h/%h exp busy 1 pos %h/%h",
                     c, bus.busy, bus.pos_h, bus.pos_v, ph, pv);
         end
         tick();
      end
      bus.vblank = 1'b1;
      tick();
      n_vec++;
      if (bus.updated !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release updated: got %b exp 1", bus.updated);
      end
      tick();
      check_pos("hold_commit");
   endtask

   task automatic test_overrun();
      do_reset(8'($urandom), 0);
      bus.vblank = 1'b0;
      bus.frame_start = 1'b1;
      void'(m_frame());
      m_step();
      tick();
      bus.frame_start = 1'b0;
      repeat (NB + 4) tick();
      n_vec++;
      if (bus.overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_pre: got %b exp 0", bus.overrun);
      end
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_vec++;
      if (bus.overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_set: got %b exp 1", bus.overrun);
      end
      bus.vblank = 1'b1;
      repeat (2) tick();
      check_pos("overrun_commit");
      repeat (3) tick();
      n_vec++;
      if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_sticky: got ovr %b busy %b exp ovr 1 busy 0", bus.overrun, bus.busy);
      end
   endtask

   task automatic test_commit_collide();
      do_reset(8'($urandom), 0);
      bus.frame_start = 1'b1;
      void'(m_frame());
      m_step();
      for (int j = 1; j <= NB + 2; j++) begin
         tick();
         if (j == 1) bus.frame_start = 1'b0;
      end
      n_vec++;
      if (bus.updated !== 1'b1) begin
         n_err++;
         $display("FAIL collide_in_commit: got updated %b exp 1", bus.updated);
      end
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_vec++;
      if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL collide_drop: got ovr %b busy %b exp ovr 1 busy 0", bus.overrun, bus.busy);
      end
      check_pos("collide_pos");
   endtask

   task automatic test_reset_mid_sweep();
      logic [7:0] sd2;
      bit trig;
      do_reset(8'($urandom), 0);
      sd2 = 8'($urandom);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick(); tick();
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL midsweep_busy: got %b exp 1", bus.busy);
      end
      reset = 1'b1;
      bus.start_dir = sd2;
      tick();
      m_reset(sd2, 0);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.updated !== 1'b0 || bus.overrun !== 1'b0) begin
         n_err++;
         $display("FAIL midsweep_reset flags: got %b%b%b exp 000", bus.busy, bus.updated, bus.overrun);
      end
      check_pos("midsweep_reset");
      reset = 1'b0;
      frame_and_commit("midsweep_after", 1'b0, trig);
   endtask

`ifdef SCHED_PAUSE_EN
   task automatic test_pause();
      int u0;
      bit trig;
      do_reset(8'($urandom), 1);
      frame_and_commit("pause_pre", 1'b0, trig);
      u0 = upd_cnt;
      pause = 1'b1;
      for (int f = 0; f < 5; f++) begin
         bus.frame_start = 1'b1;
         tick();
         bus.frame_start = 1'b0;
         repeat (NB + 6) tick();
      end
      n_vec++;
      if (upd_cnt != u0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL pause_hold: got %0d commits busy %b exp 0 commits busy 0", upd_cnt - u0, bus.busy);
      end
      check_pos("pause_pos");
      pause = 1'b0;
      for (int f = 0; f < 4; f++) begin
         frame_and_commit("pause_resume", 1'b0, trig);
         repeat (3) tick();
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.frame_start = 1'b0;
      bus.vblank = 1'b1;
      bus.top = 8'd0;
      bus.start_dir = '0;
`ifdef SCHED_PAUSE_EN
      pause = 1'b0;
`endif
      test_reset();
      test_first_step();
      test_top2();
      test_bounce();
      test_random_walk();
      test_vblank_hold();
      test_overrun();
      test_commit_collide();
      test_reset_mid_sweep();
`ifdef SCHED_PAUSE_EN
      test_pause();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ball_motion_scheduler.md
# ball_motion_scheduler

Sequences motion for up to NBALLS bouncing balls. One shared bounce/step datapath is time-multiplexed across all balls, and the results are committed to the renderers only during vertical blanking. Each commit publishes a tear-free set of 7-bit centre coordinates on a flat bus, which feeds one sphere renderer per ball. The block sits between the VGA timing generator and the sphere renderers.

## Interface
Parameters:
- NBALLS, 4: number of balls, 1..8.
- LO_BOUND, 10: a coordinate below this forces the direction to increment.
- H_HI_BOUND, 70: a horizontal coordinate above this forces the direction to decrement.
- V_HI_BOUND, 50: a vertical coordinate above this forces the direction to decrement.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse per video frame.
- vblank  in  1  high during vertical blanking.
- top  in  8  number of frames between motion steps, minus one.
- start_dir  in  2*NBALLS  initial directions, sampled while reset is high. Bit 2i is dir_h of ball i, bit 2i+1 is dir_v of ball i; 1 = increment.
- pos_h  out  7*NBALLS  committed horizontal centres; ball i occupies bits [7i+6:7i].
- pos_v  out  7*NBALLS  committed vertical centres, same packing.
- updated  out  1  one-cycle pulse on the commit cycle.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; set when a step trigger arrives while busy.

## Operation
- Reset values:
  - Shadow and committed pos_h[i] = 16+8i, pos_v[i] = 32.
  - Directions loaded from start_dir.
  - Frame counter 0, state IDLE.
  - updated = 0, busy = 0, overrun = 0.
- Frame counter:
  - Increments on each frame_start.
  - When frame_start arrives with counter == top, the counter clears and a step trigger fires.
  - top = 0 triggers on every frame.
  - The counter keeps running in every state.
- States: IDLE, SWEEP, WAIT_VBL, COMMIT.
  - IDLE: a trigger moves to SWEEP with index k = 0.
  - SWEEP: one ball per cycle, on ball k.
    - Compute new dir_h: 1 if h < LO_BOUND; 0 if h > H_HI_BOUND; otherwise unchanged. Compute new dir_v the same way using V_HI_BOUND.
    - Write the shadow coordinates h ± 1 and v ± 1 using the new directions. Arithmetic is 7-bit modulo 128.
    - Increment k. After k = NBALLS-1, go to WAIT_VBL.
  - WAIT_VBL: when vblank = 1, go to COMMIT; otherwise stay.
  - COMMIT: copy the shadow coordinates to pos_h and pos_v, pulse updated, return to IDLE.
- A trigger in any state other than IDLE is dropped and sets overrun.
  - overrun clears only on reset.
- pos_h and pos_v change only in COMMIT, never during active video.
- Reset asserted mid-sweep aborts the sweep. All state returns to reset values, and start_dir is re-sampled.

## Timing
- Trigger sampled at cycle t:
  - SWEEP occupies cycles t+1 .. t+NBALLS.
  - With vblank already high, WAIT_VBL is at t+NBALLS+1, COMMIT at t+NBALLS+2, and the new outputs are visible at t+NBALLS+3.
  - Worst-case latency is bounded by one frame plus NBALLS+3 cycles.
- busy is registered: high from t+1 through the COMMIT cycle inclusive.
- updated is high for exactly the COMMIT cycle.
- If frame_start and the COMMIT cycle coincide, the trigger is evaluated against state COMMIT. It is therefore dropped and sets overrun.

## Configuration
- SCHED_PAUSE_EN defined:
  - Adds input `pause` (1 bit).
  - While pause = 1, the frame counter holds and no trigger fires.
  - A sweep already started completes and commits normally.
- SCHED_PAUSE_EN undefined: the port does not exist and the counter behaves as described above.

## Test plan
- Reset with start_dir = 8'b01_10_11_00, top = 0, vblank held high, one frame_start: after commit, ball0 = (15,31), ball1 = (25,33), ball2 = (31,33), ball3 = (41,31). updated pulses once, at t+NBALLS+2.
- top = 2: three frame_start pulses are needed per step, and only the third starts SWEEP. Counter wrap is checked over 9 frames, giving 3 commits.
- Ball at h = 71 with dir_h = 1: the next step yields h = 70 with dir_h = 0. Ball at v = 9 with dir_v = 0: the next step yields v = 10 with dir_v = 1.
- vblank held low for 500 cycles after the sweep: pos_h and pos_v stay unchanged and busy stays high. Raising vblank gives a commit 2 cycles later.
- A second frame_start trigger during WAIT_VBL sets overrun, and the current commit proceeds unaffected. Reset asserted in SWEEP at k = 2 restores the initial positions, with busy = 0 on the following cycle.
- With SCHED_PAUSE_EN: pause = 1 for 5 frames gives no commit. After pause drops, the counter resumes from its held value.
